// File: rtl/axil_reg_slice.sv
// AXI4-Lite register slice: a two-entry skid buffer on each of AW, W, AR, B, R.
// Optional error counter on B/R responses is built when AXIL_REG_SLICE_ERRCNT_EN is defined.

module axil_reg_slice_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_valid, skid_next, rdy;
  logic [W-1:0] skid_data;
  logic         in_hs, out_hs;

  assign in_hs    = in_valid & rdy;
  assign out_hs   = out_valid & out_ready;
  assign in_ready = rdy;

  // Skid only fills when the output is occupied and stalled; ready is its registered inverse.
  always_comb begin
    skid_next = skid_valid;
    if (skid_valid) begin
      if (out_hs) skid_next = 1'b0;
    end else if (in_hs && out_valid && !out_hs) begin
      skid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      rdy        <= 1'b0;
    end else begin
      skid_valid <= skid_next;
      rdy        <= ~skid_next;
      if (!skid_valid) begin
        if (in_hs)       out_valid <= 1'b1;
        else if (out_hs) out_valid <= 1'b0;
      end
    end
  end

  // Payload flops carry no reset; the valid flags qualify them.
  always_ff @(posedge clk) begin
    if (skid_valid) begin
      if (out_hs) out_data <= skid_data;
    end else if (in_hs) begin
      if (!out_valid || out_hs) out_data  <= in_data;
      else                      skid_data <= in_data;
    end
  end
endmodule

module axil_reg_slice #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [15:0]             err_count
);
  localparam int AW_W = ADDR_WIDTH + 3;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH/8;
  localparam int R_W  = DATA_WIDTH + 2;

  axil_reg_slice_skid #(.W(AW_W)) u_aw (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .in_valid(s_axi_awvalid), .in_ready(s_axi_awready), .in_data({s_axi_awprot, s_axi_awaddr}),
    .out_valid(m_axi_awvalid), .out_ready(m_axi_awready), .out_data({m_axi_awprot, m_axi_awaddr}));

  axil_reg_slice_skid #(.W(W_W)) u_w (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .in_valid(s_axi_wvalid), .in_ready(s_axi_wready), .in_data({s_axi_wstrb, s_axi_wdata}),
    .out_valid(m_axi_wvalid), .out_ready(m_axi_wready), .out_data({m_axi_wstrb, m_axi_wdata}));

  axil_reg_slice_skid #(.W(AW_W)) u_ar (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .in_valid(s_axi_arvalid), .in_ready(s_axi_arready), .in_data({s_axi_arprot, s_axi_araddr}),
    .out_valid(m_axi_arvalid), .out_ready(m_axi_arready), .out_data({m_axi_arprot, m_axi_araddr}));

  axil_reg_slice_skid #(.W(2)) u_b (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .in_valid(m_axi_bvalid), .in_ready(m_axi_bready), .in_data(m_axi_bresp),
    .out_valid(s_axi_bvalid), .out_ready(s_axi_bready), .out_data(s_axi_bresp));

  axil_reg_slice_skid #(.W(R_W)) u_r (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .in_valid(m_axi_rvalid), .in_ready(m_axi_rready), .in_data({m_axi_rresp, m_axi_rdata}),
    .out_valid(s_axi_rvalid), .out_ready(s_axi_rready), .out_data({s_axi_rresp, s_axi_rdata}));

`ifdef AXIL_REG_SLICE_ERRCNT_EN
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic [15:0] err_q;

  // Errors are counted as responses enter the slice, so a stalled upstream does not delay the count.
  always_comb begin
    err_inc = {1'b0, m_axi_bvalid & m_axi_bready & (m_axi_bresp != 2'b00)}
            + {1'b0, m_axi_rvalid & m_axi_rready & (m_axi_rresp != 2'b00)};
    err_sum = {1'b0, err_q} + {15'd0, err_inc};
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) err_q <= 16'h0000;
    else              err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  assign err_count = err_q;
`else
  assign err_count = 16'h0000;
`endif
endmodule

// File: doc/axil_reg_slice.md
# axil_reg_slice

Full-throughput AXI4-Lite register slice on all five channels (AW, W, B, AR, R). It sits between the JTAG-to-AXI master and the AXI-Lite register file and breaks every combinational valid/ready/data path across that boundary. Each channel is a two-entry skid buffer: one output register plus one skid register. The slice adds one cycle of latency per direction and sustains one transfer per clock per channel.

## Interface
- ADDR_WIDTH, default 32: width of AWADDR and ARADDR.
- DATA_WIDTH, default 32: width of WDATA and RDATA; only 32 is supported. WSTRB is DATA_WIDTH/8 wide.
- axi_aclk  in  1  sole clock; all flops sample on its rising edge.
- axi_aresetn  in  1  reset, asynchronous and active-low.
- s_axi_{awaddr,awprot,awvalid,awready}: upstream AW; awaddr is ADDR_WIDTH, awprot is 3; awready is an output.
- s_axi_{wdata,wstrb,wvalid,wready}: upstream W; wready is an output.
- s_axi_{bresp,bvalid,bready}: upstream B; bresp is 2; bresp and bvalid are outputs.
- s_axi_{araddr,arprot,arvalid,arready}: upstream AR; arready is an output.
- s_axi_{rdata,rresp,rvalid,rready}: upstream R; rdata, rresp and rvalid are outputs.
- m_axi_*: the same 19 signals facing the register file, with directions mirrored.
- err_count  out  16  saturating count of non-OKAY responses (see Configuration).

## Operation
- Each channel is an independent slice. Forward channels: AW, W, AR (s→m). Return channels: B, R (m→s).
- Slice state per channel: out_valid, out_payload, skid_valid, skid_payload.
- Input ready = ~skid_valid. It is a registered signal and is never combinational from the output side.
- Input handshake (in_valid & in_ready):
  - If the output register is empty, or is transferring this cycle, the payload loads into the output register.
  - Otherwise the payload loads into the skid register and skid_valid is set.
- Output handshake (out_valid & out_ready) with skid_valid=1: the skid payload moves into the output register and skid_valid clears.
- Output handshake with skid_valid=0 and no new input: out_valid clears.
- Order is preserved. Transfers are never dropped, duplicated or reordered.
- Payload bits: AW = addr+prot; W = data+strb; AR = addr+prot; B = resp; R = data+resp.
- The slice does not couple AW with W. Ordering between channels is left to the endpoints.
- Payload registers have no reset. Only the valid flags, ready flags and err_count are reset.

## Timing
- Reset (axi_aresetn=0) is asynchronous. It immediately forces:
  - every *valid output to 0;
  - every s-side and m-side ready output (s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready) to 0;
  - err_count to 0.
- On the first rising edge after reset deasserts, all ready outputs go to 1. There is a single ready register per channel, set to 1 at that edge.
- Latency: input accepted at edge N → output valid from edge N+1.
- Throughput: with the downstream ready held at 1, one transfer per cycle and no bubbles.
- Backpressure:
  - Downstream ready drops with the output full: at most one more input is accepted (into skid), then input ready goes 0 at the next edge.
  - Ready returns to 1 at the edge after the skid drains.
- Simultaneous input and output handshake with skid empty: the output register takes the new payload and out_valid stays 1.
- Once asserted, out_valid holds with a stable payload until the handshake completes.
- Reset asserted mid-transfer discards all in-flight entries. Upstream must also be reset.

## Configuration
- AXIL_REG_SLICE_ERRCNT_EN defined:
  - err_count increments by 1 on each B handshake with bresp≠2'b00.
  - err_count increments by 1 on each R handshake with rresp≠2'b00.
  - Both on the same cycle: +2.
  - err_count saturates at 16'hFFFF.
  - The count is taken on the m side, at acceptance into the slice.
- Not defined: err_count is tied to 16'h0000 and no counter logic is built.

## Test plan
- Reset: hold axi_aresetn=0 → all valids and readies 0. Release → all readies 1 at the first edge; err_count=0.
- Streaming: 8 back-to-back AR (0x00,0x04,…,0x1C) with m_axi_arready=1 → m_axi_araddr emits the same 8 values one per cycle, each one cycle after its input.
- Backpressure: m_axi_awready=0 while 3 AW are offered → first two are accepted, s_axi_awready goes 0. Raise m_axi_awready → the two pending transfers emerge in order, then the third is accepted.
- Write path: AW 0x0C plus W 0x0000000F, wstrb 4'hF, slave returns bresp=0 → upstream sees bvalid once with bresp=0.
- Error counting: with ERRCNT_EN, return rresp=2'b10 three times and bresp=2'b11 once → err_count=4. Without the macro → err_count=0.
- Random stall: 1000 random reads/writes with random ready toggling on both sides → scoreboard matches every payload in order; no valid drops without a handshake.
